param_pipe_mac: RTL and testbench
=================================

Name: param_pipe_mac

Overview:
- Parametrised successor to the fixed 14b/28b, 4-stage multiply-accumulate unit in the convolution datapath.
- Generalises operand width, accumulator width and multiplier pipeline depth.
- Adds vector framing: a last_in tag closes a dot product, and the next valid element starts a fresh sum. This is what a convolution window needs.
- Sits between the window/weight fetch logic and the output buffer.

Parameters:
- IN_W, 14, signed operand width of a_in and b_in.
- ACC_W, 28, signed accumulator/output width. Must be at least 2*IN_W; elaboration fails otherwise.
- MULT_STAGES, 4, register stages inside the multiplier. Legal range 1..8.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- valid_in  in  1  a_in, b_in and last_in are valid this cycle.
- a_in  in  IN_W  signed operand.
- b_in  in  IN_W  signed operand.
- last_in  in  1  element is the final one of the current vector; ignored when valid_in=0.
- f  out  ACC_W  signed saturated running sum.
- valid_out  out  1  f was updated by an element in this cycle.
- last_out  out  1  f is the completed vector result (qualified by valid_out).
- sat_out  out  1  sticky: some addition in the current vector saturated (qualified by valid_out).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: on any edge with reset=1, the following are all cleared to 0, with no partial results emitted afterwards:
  - f, valid_out, last_out, sat_out;
  - input registers, multiplier stages, product register;
  - every valid/last tag in the pipeline;
  - the internal first-element flag is set to 1.
- Pipeline: free-running with no stall or back-pressure. Each element carries a valid tag and a last tag through every stage.
- Stage 0: on edge E0 with valid_in=1, load a_in, b_in and last_in into the input registers. With valid_in=0, the operand registers hold and a 0 tag is shifted in.
- Multiplier: signed IN_W x IN_W product, fully registered through MULT_STAGES stages. The full 2*IN_W product is exact and is sign-extended to ACC_W at the product register (stage MULT_STAGES+1).
- Accumulate: at edge E0+MULT_STAGES+2, a tagged element updates f, and valid_out, last_out and sat_out change on that same edge.
  - Total latency L = MULT_STAGES+2 edges. Default L = 6.
- Sum rule:
  - If the first-element flag is 1: f <= product, and the flag clears.
  - Otherwise: f <= sat(f + product).
  - If the element carries last: the flag sets again, so the next element starts fresh.
- Saturation:
  - Positive overflow (both operands >0, raw sum <0) clamps to 2^(ACC_W-1)-1.
  - Negative overflow (both <0, raw sum >=0) clamps to -2^(ACC_W-1).
  - The first element of a vector cannot saturate.
- sat_out: set on any clamp and stays set until the first element of the next vector. The output for that first element shows only that element's saturation, which is always 0.
- Bubbles: cycles with valid_in=0 produce untagged slots. When an untagged slot reaches the accumulator, f holds and valid_out=0, last_out=0, sat_out holds.
  - Gaps within a vector are allowed and do not change the result.
- Back-to-back vectors: last_in on element k and a new element on the next cycle is legal. The new sum starts from the product alone, with no cycle lost.
- Single-element vector: valid_in=1 with last_in=1 gives f = product, last_out=1.
- last_out and valid_out: last_out=1 only when valid_out=1.

Decomposition:
- Package mac_pkg holds:
  - the default width constants IN_W_DEF, ACC_W_DEF, MULT_STAGES_DEF;
  - the function sat_add(a, b) returning the clamped sum;
  - the typedef mac_tag_t (packed valid, last).
- Sub-module pipe_mult holds the parametrised signed multiplier with MULT_STAGES output-retiming registers and a tag shift register alongside the data.
- Control, input registers, product register and accumulator stay in param_pipe_mac.

Test Plan:
- Reset then vector (3,4), (-2,5), (7,7) with last on the 3rd element, defaults -> valid_out at E0+6, E0+7, E0+8 with f = 12, 2, 51; last_out only with f=51; sat_out=0.
- Two vectors back-to-back: [(1,1),(2,2) last] then [(10,10) last] -> f = 1, 5 (last_out), then 100 (last_out), with no carry-over.
- Positive saturation, defaults: (8191,8191) repeated 3 times, then (1,1) last. Each product is 67092481. Running sums are 67092481 then 134184962 (max is 134217727, so no clamp yet); the third add clamps to 134217727 with sat_out=1; the last element stays at 134217727 with sat_out=1 and last_out=1. Repeat with (-8192,8191) products and check the clamp to -134217728.
- Bubbles: the first vector with two idle cycles between elements gives the same values as the contiguous run; valid_out is low for exactly those two slots and f holds.
- Reset asserted one cycle after a valid element -> no valid_out ever emitted for it; f=0. The next vector accumulates from zero.
- MULT_STAGES=1, IN_W=8, ACC_W=20: (-128,-128) last -> f=16384 at E0+3, last_out=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, tag type and saturating adder for the parametrised pipelined MAC.
package mac_pkg;

  localparam int IN_W_DEF        = 14;
  localparam int ACC_W_DEF       = 28;
  localparam int MULT_STAGES_DEF = 4;

  // Working width of sat_add; accumulators up to SAT_W-1 bits are supported.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic valid;
    logic last;
  } mac_tag_t;

  // Add two sign-extended w-bit values and clamp the result to the signed w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      sat_add = max_v;
    end else if (sum < min_v) begin
      sat_add = min_v;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/param_pipe_mac_mult.sv
// Signed IN_W x IN_W multiplier with MULT_STAGES output-retiming registers and a
// valid/last tag shift register that moves in lockstep with the data.
module pipe_mult
  import mac_pkg::*;
#(
  parameter int IN_W        = IN_W_DEF,
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_W-1:0]     a,
  input  logic [IN_W-1:0]     b,
  input  logic [1:0]          tag_in,
  output logic [2*IN_W-1:0]   p,
  output logic [1:0]          tag_out
);

  logic signed [2*IN_W-1:0] a_ext;
  logic signed [2*IN_W-1:0] b_ext;
  logic signed [2*IN_W-1:0] p_d   [MULT_STAGES];
  logic signed [2*IN_W-1:0] p_q   [MULT_STAGES];
  mac_tag_t                 tag_d [MULT_STAGES];
  mac_tag_t                 tag_q [MULT_STAGES];

  // Product into the first stage, then plain shift through the remaining stages.
  always_comb begin
    a_ext    = (2*IN_W)'($signed(a));
    b_ext    = (2*IN_W)'($signed(b));
    p_d[0]   = a_ext * b_ext;
    tag_d[0] = mac_tag_t'(tag_in);
    for (int i = 1; i < MULT_STAGES; i++) begin
      p_d[i]   = p_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // Stage registers; reset flushes data and tags so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        p_q[i]   <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        p_q[i]   <= p_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign p       = p_q[MULT_STAGES-1];
  assign tag_out = tag_q[MULT_STAGES-1];

endmodule

// File: rtl/param_pipe_mac.sv
// Pipelined signed multiply-accumulate with vector framing: last_in closes a dot
// product and the next valid element starts a fresh, saturating sum.
module param_pipe_mac
  import mac_pkg::*;
#(
  parameter int IN_W        = IN_W_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int MULT_STAGES = MULT_STAGES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [IN_W-1:0]   a_in,
  input  logic [IN_W-1:0]   b_in,
  input  logic              last_in,
  output logic [ACC_W-1:0]  f,
  output logic              valid_out,
  output logic              last_out,
  output logic              sat_out
);

  if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
    $error("param_pipe_mac: ACC_W must be at least 2*IN_W");
  end
  if (ACC_W > SAT_W - 1) begin : g_bad_acc_max
    $error("param_pipe_mac: ACC_W exceeds the saturating adder width");
  end
  if (MULT_STAGES < 1 || MULT_STAGES > 8) begin : g_bad_stages
    $error("param_pipe_mac: MULT_STAGES must be in 1..8");
  end

  logic [IN_W-1:0]         a_d, a_q, b_d, b_q;
  mac_tag_t                in_tag_d, in_tag_q;
  logic [2*IN_W-1:0]       mult_p;
  logic [1:0]              mult_tag;
  logic signed [ACC_W-1:0] prod_d, prod_q, f_d, f_q;
  mac_tag_t                prod_tag_d, prod_tag_q;
  logic                    valid_out_d, valid_out_q, last_out_d, last_out_q;
  logic                    sat_d, sat_q, first_d, first_q;
  logic signed [SAT_W-1:0] f_ext, prod_ext, raw_sum, clamped_sum;

  // Input capture: operands hold on idle cycles while an empty tag enters the pipe.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    in_tag_d = '0;
    if (valid_in) begin
      a_d            = a_in;
      b_d            = b_in;
      in_tag_d.valid = 1'b1;
      in_tag_d.last  = last_in;
    end else begin
      in_tag_d = '0;
    end
  end

  pipe_mult #(
    .IN_W        (IN_W),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .a       (a_q),
    .b       (b_q),
    .tag_in  (in_tag_q),
    .p       (mult_p),
    .tag_out (mult_tag)
  );

  // Product register sign-extends the exact product to the accumulator width.
  always_comb begin
    prod_d     = ACC_W'($signed(mult_p));
    prod_tag_d = mac_tag_t'(mult_tag);
  end

  // Accumulator next state; untagged slots hold f and sat, and drop valid/last.
  always_comb begin
    f_ext       = SAT_W'(f_q);
    prod_ext    = SAT_W'(prod_q);
    raw_sum     = f_ext + prod_ext;
    clamped_sum = sat_add(f_ext, prod_ext, ACC_W);
    f_d         = f_q;
    sat_d       = sat_q;
    first_d     = first_q;
    valid_out_d = 1'b0;
    last_out_d  = 1'b0;
    if (prod_tag_q.valid) begin
      valid_out_d = 1'b1;
      last_out_d  = prod_tag_q.last;
      // A closing element re-arms the flag, so first&last yields first_d=1 as well.
      first_d     = prod_tag_q.last;
      if (first_q) begin
        f_d   = prod_q;
        sat_d = 1'b0;
      end else begin
        f_d   = clamped_sum[ACC_W-1:0];
        sat_d = sat_q | (clamped_sum != raw_sum);
      end
    end else begin
      valid_out_d = 1'b0;
    end
  end

  // All pipeline and accumulator state, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      in_tag_q    <= '0;
      prod_q      <= '0;
      prod_tag_q  <= '0;
      f_q         <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      sat_q       <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      in_tag_q    <= in_tag_d;
      prod_q      <= prod_d;
      prod_tag_q  <= prod_tag_d;
      f_q         <= f_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      sat_q       <= sat_d;
      first_q     <= first_d;
    end
  end

  assign f         = f_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign sat_out   = sat_q;

endmodule

// File: tb/tb_param_pipe_mac.sv
// Directed bench for param_pipe_mac: default instance (L=6) plus a narrow
// MULT_STAGES=1, IN_W=8, ACC_W=20 instance (L=3).
module tb_param_pipe_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, last_in;
  logic [13:0] a_in, b_in;
  logic [27:0] f;
  logic        valid_out, last_out, sat_out;

  logic        valid_in2, last_in2;
  logic [7:0]  a_in2, b_in2;
  logic [19:0] f2;
  logic        valid_out2, last_out2, sat_out2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [30:0] obs;
  logic [22:0] obs2;
  assign obs  = {valid_out, last_out, sat_out, f};
  assign obs2 = {valid_out2, last_out2, sat_out2, f2};

  param_pipe_mac dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .a_in(a_in), .b_in(b_in),
    .last_in(last_in), .f(f), .valid_out(valid_out), .last_out(last_out), .sat_out(sat_out)
  );

  param_pipe_mac #(.IN_W(8), .ACC_W(20), .MULT_STAGES(1)) dut2 (
    .clk(clk), .reset(reset), .valid_in(valid_in2), .a_in(a_in2), .b_in(b_in2),
    .last_in(last_in2), .f(f2), .valid_out(valid_out2), .last_out(last_out2), .sat_out(sat_out2)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] o(input logic v, input logic l, input logic s, input int fv);
    logic [31:0] t;
    t = fv;
    return {v, l, s, t[27:0]};
  endfunction

  function automatic logic [22:0] o2(input logic v, input logic l, input logic s, input int fv);
    logic [31:0] t;
    t = fv;
    return {v, l, s, t[19:0]};
  endfunction

  task automatic cyc(input logic v, input int a, input int b, input logic l);
    logic [31:0] ta, tb;
    ta = a;
    tb = b;
    valid_in = v;
    a_in     = ta[13:0];
    b_in     = tb[13:0];
    last_in  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input logic v, input int a, input int b, input logic l);
    logic [31:0] ta, tb;
    ta = a;
    tb = b;
    valid_in2 = v;
    a_in2     = ta[7:0];
    b_in2     = tb[7:0];
    last_in2  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    n_checks++;
    if (obs !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_dut got %h exp 0", obs);
    end
    n_checks++;
    if (obs2 !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_dut2 got %h exp 0", obs2);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [30:0] exp_t [4];
    exp_t = '{o(1'b1, 1'b0, 1'b0, 12), o(1'b1, 1'b0, 1'b0, 2),
              o(1'b1, 1'b1, 1'b0, 51), o(1'b0, 1'b0, 1'b0, 51)};
    cyc(1'b1, 3, 4, 1'b0);
    cyc(1'b1, -2, 5, 1'b0);
    cyc(1'b1, 7, 7, 1'b1);
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early valid_out=%b exp 0", valid_out);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL basic[%0d] got v/l/s/f=%h exp %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [30:0] exp_t [4];
    exp_t = '{o(1'b1, 1'b0, 1'b0, 1), o(1'b1, 1'b1, 1'b0, 5),
              o(1'b1, 1'b1, 1'b0, 100), o(1'b0, 1'b0, 1'b0, 100)};
    cyc(1'b1, 1, 1, 1'b0);
    cyc(1'b1, 2, 2, 1'b1);
    cyc(1'b1, 10, 10, 1'b1);
    repeat (3) cyc(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL b2b[%0d] got v/l/s/f=%h exp %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_pos_sat();
    logic [30:0] exp_t [5];
    exp_t = '{o(1'b1, 1'b0, 1'b0, 67092481), o(1'b1, 1'b0, 1'b0, 134184962),
              o(1'b1, 1'b0, 1'b1, 134217727), o(1'b1, 1'b1, 1'b1, 134217727),
              o(1'b0, 1'b0, 1'b1, 134217727)};
    repeat (3) cyc(1'b1, 8191, 8191, 1'b0);
    cyc(1'b1, 1, 1, 1'b1);
    repeat (2) cyc(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL pos_sat[%0d] got v/l/s/f=%h exp %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_neg_sat();
    logic [30:0] exp_t [5];
    exp_t = '{o(1'b1, 1'b0, 1'b0, -67100672), o(1'b1, 1'b0, 1'b0, -134201344),
              o(1'b1, 1'b0, 1'b1, -134217728), o(1'b1, 1'b1, 1'b1, -134217727),
              o(1'b0, 1'b0, 1'b1, -134217727)};
    repeat (3) cyc(1'b1, -8192, 8191, 1'b0);
    cyc(1'b1, 1, 1, 1'b1);
    repeat (2) cyc(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL neg_sat[%0d] got v/l/s/f=%h exp %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [30:0] exp_t [6];
    exp_t = '{o(1'b1, 1'b0, 1'b0, 12), o(1'b0, 1'b0, 1'b0, 12),
              o(1'b1, 1'b0, 1'b0, 2),  o(1'b0, 1'b0, 1'b0, 2),
              o(1'b1, 1'b1, 1'b0, 51), o(1'b0, 1'b0, 1'b0, 51)};
    cyc(1'b1, 3, 4, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b1, -2, 5, 1'b0);
    cyc(1'b0, 0, 0, 1'b0);
    cyc(1'b1, 7, 7, 1'b1);
    cyc(1'b0, 0, 0, 1'b0);
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bubbles_early valid_out=%b exp 0", valid_out);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL bubbles[%0d] got v/l/s/f=%h exp %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] exp_t [2];
    exp_t = '{o(1'b1, 1'b0, 1'b0, 6), o(1'b1, 1'b1, 1'b0, 7)};
    cyc(1'b1, 5, 5, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== 31'd0) begin
        n_fail++;
        $display("FAIL reset_mid_flush[%0d] got v/l/s/f=%h exp 0", i, obs);
      end
    end
    cyc(1'b1, 2, 3, 1'b0);
    cyc(1'b1, 1, 1, 1'b1);
    repeat (4) cyc(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs !== exp_t[i]) begin
        n_fail++;
        $display("FAIL reset_mid_after[%0d] got v/l/s/f=%h exp %h", i, obs, exp_t[i]);
      end
    end
  endtask

  task automatic test_small();
    logic [22:0] exp_t [3];
    exp_t = '{o2(1'b1, 1'b1, 1'b0, 16384), o2(1'b1, 1'b1, 1'b0, -16256),
              o2(1'b0, 1'b0, 1'b0, -16256)};
    cyc2(1'b1, -128, -128, 1'b1);
    cyc2(1'b1, 127, -128, 1'b1);
    cyc2(1'b0, 0, 0, 1'b0);
    n_checks++;
    if (valid_out2 !== 1'b0) begin
      n_fail++;
      $display("FAIL small_early valid_out=%b exp 0", valid_out2);
    end
    for (int i = 0; i < 3; i++) begin
      cyc2(1'b0, 0, 0, 1'b0);
      n_checks++;
      if (obs2 !== exp_t[i]) begin
        n_fail++;
        $display("FAIL small[%0d] got v/l/s/f=%h exp %h", i, obs2, exp_t[i]);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    valid_in  = 1'b0;
    last_in   = 1'b0;
    a_in      = 14'd0;
    b_in      = 14'd0;
    valid_in2 = 1'b0;
    last_in2  = 1'b0;
    a_in2     = 8'd0;
    b_in2     = 8'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_pos_sat();
    test_neg_sat();
    test_bubbles();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
